// File: rtl/sprite_overlay_pipe_if.sv
// rtl/sprite_overlay_pipe_if.sv - pixel, timing, control and image ROM signals of the sprite overlay stage
interface sprite_overlay_pipe_if #(
  parameter int ADDR_W = 12
);
  logic [10:0]       hcount_in;
  logic [10:0]       vcount_in;
  logic              hs_in;
  logic              vs_in;
  logic              hblnk_in;
  logic              vblnk_in;
  logic [11:0]       rgb_in;
  logic [11:0]       xpos;
  logic [11:0]       ypos;
  logic              en;
  logic              scale_2x;
  logic [ADDR_W-1:0] pixel_addr;
  logic [11:0]       rom_rgb;
  logic [10:0]       hcount_out;
  logic [10:0]       vcount_out;
  logic              hs_out;
  logic              vs_out;
  logic              hblnk_out;
  logic              vblnk_out;
  logic [3:0]        r;
  logic [3:0]        g;
  logic [3:0]        b;

  modport master (
    output hcount_in, vcount_in, hs_in, vs_in, hblnk_in, vblnk_in, rgb_in,
    output xpos, ypos, en, scale_2x, rom_rgb,
    input  pixel_addr, hcount_out, vcount_out, hs_out, vs_out, hblnk_out, vblnk_out,
    input  r, g, b
  );

  modport slave (
    input  hcount_in, vcount_in, hs_in, vs_in, hblnk_in, vblnk_in, rgb_in,
    input  xpos, ypos, en, scale_2x, rom_rgb,
    output pixel_addr, hcount_out, vcount_out, hs_out, vs_out, hblnk_out, vblnk_out,
    output r, g, b
  );
endinterface

// File: rtl/sprite_overlay_pipe.sv
// rtl/sprite_overlay_pipe.sv - sprite overlay from a synchronous image ROM with timing kept aligned
module sprite_overlay_pipe #(
  parameter int          SPR_W      = 48,
  parameter int          SPR_H      = 64,
  parameter int          ADDR_W     = 12,
  parameter int          ROM_LAT    = 1,
  parameter logic [11:0] TRANSP_KEY = 12'hF0F
) (
  input  logic                  pclk,
  input  logic                  rst,
  sprite_overlay_pipe_if.slave  bus
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hs;
    logic        vs;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_box;
  } pix_t;

  localparam logic signed [12:0] W1 = 13'(SPR_W);
  localparam logic signed [12:0] W2 = 13'(2 * SPR_W);
  localparam logic signed [12:0] H1 = 13'(SPR_H);
  localparam logic signed [12:0] H2 = 13'(2 * SPR_H);

  // Position/mode are sampled only at the vblank rising edge so a frame never tears.
  logic        vblnk_prev;
  logic [11:0] xpos_l;
  logic [11:0] ypos_l;
  logic        en_l;
  logic        scale_l;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      vblnk_prev <= 1'b0;
      xpos_l     <= '0;
      ypos_l     <= '0;
      en_l       <= 1'b0;
      scale_l    <= 1'b0;
    end else begin
      vblnk_prev <= bus.vblnk_in;
      if (bus.vblnk_in && !vblnk_prev) begin
        xpos_l  <= bus.xpos;
        ypos_l  <= bus.ypos;
        en_l    <= bus.en;
        scale_l <= bus.scale_2x;
      end
    end
  end

  // 13-bit signed offsets cannot wrap, so positions >= 2048 always give dx/dy < 0.
  logic signed [12:0] dx;
  logic signed [12:0] dy;
  logic signed [12:0] w_lim;
  logic signed [12:0] h_lim;
  logic [11:0]        col;
  logic [11:0]        row;
  logic               in_box;
  logic [ADDR_W-1:0]  addr_c;

  always_comb begin
    dx     = $signed({2'b00, bus.hcount_in}) - $signed({1'b0, xpos_l});
    dy     = $signed({2'b00, bus.vcount_in}) - $signed({1'b0, ypos_l});
    w_lim  = scale_l ? W2 : W1;
    h_lim  = scale_l ? H2 : H1;
    in_box = en_l && !dx[12] && (dx < w_lim) && !dy[12] && (dy < h_lim);
    col    = dx[11:0] >> scale_l;
    row    = dy[11:0] >> scale_l;
    addr_c = ADDR_W'(32'(row) * 32'(SPR_W) + 32'(col));
  end

  logic [ADDR_W-1:0] pixel_addr_q;
  pix_t              pipe [0:ROM_LAT];

  always_ff @(posedge pclk) begin
    if (!rst) begin
      pixel_addr_q <= '0;
      for (int k = 0; k <= ROM_LAT; k++) pipe[k] <= '0;
    end else begin
      pixel_addr_q <= in_box ? addr_c : '0;
      pipe[0]      <= {bus.hcount_in, bus.vcount_in, bus.hs_in, bus.vs_in,
                       bus.hblnk_in, bus.vblnk_in, bus.rgb_in, in_box};
      for (int k = 1; k <= ROM_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // The tail of the delay line lines up with the ROM word for the same pixel.
  pix_t        tail;
  logic [11:0] rgb_sel;

  assign tail = pipe[ROM_LAT];

  always_comb begin
    rgb_sel = tail.rgb;
    if (tail.hblnk || tail.vblnk)
      rgb_sel = '0;
    else if (tail.in_box && (bus.rom_rgb != TRANSP_KEY))
      rgb_sel = bus.rom_rgb;
  end

  logic [25:0] timing_q;
  logic [11:0] rgb_q;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      timing_q <= '0;
      rgb_q    <= '0;
    end else begin
      timing_q <= {tail.hcount, tail.vcount, tail.hs, tail.vs, tail.hblnk, tail.vblnk};
      rgb_q    <= rgb_sel;
    end
  end

  assign bus.pixel_addr = pixel_addr_q;
  assign {bus.hcount_out, bus.vcount_out, bus.hs_out, bus.vs_out, bus.hblnk_out, bus.vblnk_out} = timing_q;
  assign {bus.r, bus.g, bus.b} = rgb_q;

endmodule

// File: tb/tb_sprite_overlay_pipe.sv
// tb/tb_sprite_overlay_pipe.sv - randomized and directed bench for sprite_overlay_pipe at ROM_LAT 1 and 3
module tb_sprite_overlay_pipe;
  localparam int NMAX = 16384;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  sprite_overlay_pipe_if #(.ADDR_W(12)) bus_a ();
  sprite_overlay_pipe_if #(.ADDR_W(12)) bus_b ();

  sprite_overlay_pipe #(.SPR_W(48), .SPR_H(64), .ADDR_W(12), .ROM_LAT(1), .TRANSP_KEY(12'hF0F))
    dut_a (.pclk(pclk), .rst(rst), .bus(bus_a.slave));
  sprite_overlay_pipe #(.SPR_W(48), .SPR_H(64), .ADDR_W(12), .ROM_LAT(3), .TRANSP_KEY(12'hF0F))
    dut_b (.pclk(pclk), .rst(rst), .bus(bus_b.slave));

  // Image content: the address itself, except every 97th word (offset 5) is the colour key.
  function automatic logic [11:0] rom_val(input logic [11:0] a);
    if (a % 12'd97 == 12'd5) return 12'hF0F;
    return a;
  endfunction

  logic [11:0] rom_a;
  logic [11:0] rom_b [0:2];
  always @(posedge pclk) begin
    rom_a    <= rom_val(bus_a.pixel_addr);
    rom_b[0] <= rom_val(bus_b.pixel_addr);
    rom_b[1] <= rom_b[0];
    rom_b[2] <= rom_b[1];
  end
  assign bus_a.rom_rgb = rom_a;
  assign bus_b.rom_rgb = rom_b[2];

  int r_hc [NMAX], r_vc [NMAX], r_rgb [NMAX], r_addr [NMAX];
  bit r_hs [NMAX], r_vs [NMAX], r_hb [NMAX], r_vb [NMAX], r_ib [NMAX], r_rst [NMAX];

  int n = 0;
  int checks = 0;
  int passes = 0;
  int xl = 0, yl = 0;
  bit el = 0, sl = 0, pvb = 0;
  bit cur_rst = 0, cur_en = 0, cur_sc = 0;
  int cur_x = 0, cur_y = 0;
  int ph = 0, fb_v = -1, last_rgb = 0;

  task automatic check(input string nm, input int c, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, c, got, exp);
  endtask

  task automatic pins(input int hc, input int vc);
    int i;
    i = n - 1;
    case (ph)
      1: begin
        if (hc == 100 && vc == 50) check("pin_1x_origin_addr", i, r_addr[i], 0);
        if (hc == 147 && vc == 113) begin
          check("pin_1x_last_addr", i, r_addr[i], 3071);
          check("pin_1x_last_rgb", i, r_rgb[i], 12'hBFF);
        end
        if ((hc == 148 || hc == 99) && vc == 50) check("pin_1x_edge_rgb", i, r_rgb[i], last_rgb);
        if (hc == 105 && vc == 50) begin
          check("pin_key_addr", i, r_addr[i], 5);
          check("pin_key_rgb", i, r_rgb[i], last_rgb);
        end
        if (hc == 110 && vc == 51) check("pin_hblnk_rgb", i, r_rgb[i], 0);
      end
      2: begin
        if (hc == 300 && vc == 50) check("pin_moved_inbox", i, int'(r_ib[i]), 1);
        if (hc == 100 && vc == 50) check("pin_moved_old_rgb", i, r_rgb[i], last_rgb);
      end
      3: begin
        if (hc == 0 && vc == 0)    check("pin_2x_00", i, r_addr[i] + 1000 * int'(r_ib[i]), 1000);
        if (hc == 1 && vc == 1)    check("pin_2x_11", i, r_addr[i], 0);
        if (hc == 2 && vc == 0)    check("pin_2x_20", i, r_addr[i], 1);
        if (hc == 95 && vc == 0)   check("pin_2x_950", i, r_addr[i], 47);
        if (hc == 96 && vc == 0)   check("pin_2x_960_out", i, int'(r_ib[i]), 0);
        if (hc == 0 && vc == 127)  check("pin_2x_0127", i, r_addr[i], 3024);
        if (hc == 0 && vc == 128)  check("pin_2x_0128_out", i, int'(r_ib[i]), 0);
      end
      4: begin
        if (hc == 100 && vc == 50) begin
          check("pin_en0_inbox", i, int'(r_ib[i]), 0);
          check("pin_en0_rgb", i, r_rgb[i], last_rgb);
        end
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input int hc, input int vc, input bit hs, input bit vs,
                     input bit hb, input bit vb, input int rgb);
    int s, dx, dy;
    bit ib;
    @(posedge pclk);
    #1;
    if (n >= NMAX) begin
      $display("FAIL record_space @cycle %0d: got %0d, expected below %0d", n, n, NMAX);
      $fatal(1);
    end
    rst = cur_rst;
    bus_a.hcount_in = 11'(hc); bus_a.vcount_in = 11'(vc); bus_a.hs_in = hs; bus_a.vs_in = vs;
    bus_a.hblnk_in = hb; bus_a.vblnk_in = vb; bus_a.rgb_in = 12'(rgb);
    bus_a.xpos = 12'(cur_x); bus_a.ypos = 12'(cur_y); bus_a.en = cur_en; bus_a.scale_2x = cur_sc;
    bus_b.hcount_in = 11'(hc); bus_b.vcount_in = 11'(vc); bus_b.hs_in = hs; bus_b.vs_in = vs;
    bus_b.hblnk_in = hb; bus_b.vblnk_in = vb; bus_b.rgb_in = 12'(rgb);
    bus_b.xpos = 12'(cur_x); bus_b.ypos = 12'(cur_y); bus_b.en = cur_en; bus_b.scale_2x = cur_sc;
    if (!cur_rst) begin
      r_hc[n] = 0; r_vc[n] = 0; r_hs[n] = 0; r_vs[n] = 0; r_hb[n] = 0; r_vb[n] = 0;
      r_ib[n] = 0; r_addr[n] = 0; r_rgb[n] = 0;
      xl = 0; yl = 0; el = 0; sl = 0; pvb = 0;
    end else begin
      s  = sl ? 2 : 1;
      dx = hc - xl;
      dy = vc - yl;
      ib = el && dx >= 0 && dx < 48 * s && dy >= 0 && dy < 64 * s;
      r_hc[n] = hc; r_vc[n] = vc; r_hs[n] = hs; r_vs[n] = vs; r_hb[n] = hb; r_vb[n] = vb;
      r_ib[n] = ib;
      r_addr[n] = ib ? (dy / s) * 48 + dx / s : 0;
      if (hb || vb) r_rgb[n] = 0;
      else if (ib && rom_val(12'(r_addr[n])) != 12'hF0F) r_rgb[n] = int'(rom_val(12'(r_addr[n])));
      else r_rgb[n] = rgb;
      if (vb && !pvb) begin
        xl = cur_x; yl = cur_y; el = cur_en; sl = cur_sc;
      end
      pvb = vb;
    end
    r_rst[n] = cur_rst;
    last_rgb = rgb;
    n++;
    pins(hc, vc);
  endtask

  task automatic cmp(input string nm, input int lat, input int c,
                     input logic [10:0] hco, input logic [10:0] vco,
                     input logic hso, input logic vso, input logic hbo, input logic vbo,
                     input logic [11:0] rgbo, input logic [11:0] addr);
    int k;
    bit rz;
    check({nm, "_pixel_addr"}, c, int'(addr), r_addr[c-1]);
    k = c - lat;
    if (k >= 0) begin
      rz = 0;
      for (int j = k; j < c; j++) if (!r_rst[j]) rz = 1;
      if (rz) begin
        check({nm, "_timing_reset"}, c, int'({hco, vco, hso, vso, hbo, vbo}), 0);
        check({nm, "_rgb_reset"}, c, int'(rgbo), 0);
      end else begin
        check({nm, "_timing"}, c, int'({hco, vco, hso, vso, hbo, vbo}),
              int'({11'(r_hc[k]), 11'(r_vc[k]), r_hs[k], r_vs[k], r_hb[k], r_vb[k]}));
        check({nm, "_rgb"}, c, int'(rgbo), r_rgb[k]);
      end
    end
  endtask

  always @(negedge pclk) begin
    if (n >= 2) begin
      cmp("lat3", 3, n - 1, bus_a.hcount_out, bus_a.vcount_out, bus_a.hs_out, bus_a.vs_out,
          bus_a.hblnk_out, bus_a.vblnk_out, {bus_a.r, bus_a.g, bus_a.b}, bus_a.pixel_addr);
      cmp("lat5", 5, n - 1, bus_b.hcount_out, bus_b.vcount_out, bus_b.hs_out, bus_b.vs_out,
          bus_b.hblnk_out, bus_b.vblnk_out, {bus_b.r, bus_b.g, bus_b.b}, bus_b.pixel_addr);
    end
  end

  task automatic vblank_seg();
    for (int k = 0; k < 30; k++)
      cyc((k * 7) % 400, 600 + k, 1'b0, (k >= 8 && k < 12), 1'b1, 1'b1, int'($urandom_range(0, 4095)));
  endtask

  task automatic line(input int v, input int htot, input int hact, input int hs_lo, input int hs_hi);
    for (int h = 0; h < htot; h++)
      cyc(h, v, (h >= hs_lo && h <= hs_hi), 1'b0,
          (h >= hact || (v == fb_v && h >= 108 && h <= 112)), 1'b0, int'($urandom_range(0, 4095)));
  endtask

  task automatic rand_ctrl();
    cur_x  = $urandom_range(0, 1) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 300));
    cur_y  = $urandom_range(0, 1) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 200));
    cur_en = ($urandom_range(0, 3) != 0);
    cur_sc = ($urandom_range(0, 1) != 0);
  endtask

  initial begin
    bit vbr;
    int hc, vc;
    vbr = 0;
    cur_rst = 0;
    for (int i = 0; i < 5; i++) begin
      rand_ctrl();
      cyc(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), $urandom_range(0, 1) != 0,
          $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
          int'($urandom_range(0, 4095)));
    end

    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) rand_ctrl();
      if ($urandom_range(0, 15) == 0) vbr = !vbr;
      if (i == 199) vbr = 0;
      if (i == 200) vbr = 1;
      cur_rst = !(i == 200 || i == 201);
      hc = $urandom_range(0, 1) ? int'($urandom_range(0, 2047)) : (xl + int'($urandom_range(0, 110))) % 2048;
      vc = $urandom_range(0, 1) ? int'($urandom_range(0, 2047)) : (yl + int'($urandom_range(0, 140))) % 2048;
      cyc(hc, vc, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
          $urandom_range(0, 7) == 0, vbr, int'($urandom_range(0, 4095)));
    end
    cur_rst = 1;

    cur_x = 100; cur_y = 50; cur_en = 1; cur_sc = 0;
    vblank_seg();
    ph = 1; fb_v = 51;
    line(49, 400, 360, 370, 379);
    line(50, 400, 360, 370, 379);
    line(51, 400, 360, 370, 379);
    fb_v = -1; cur_x = 300;
    line(80, 400, 360, 370, 379);
    line(113, 400, 360, 370, 379);
    line(114, 400, 360, 370, 379);

    ph = 0;
    vblank_seg();
    ph = 2;
    line(50, 400, 360, 370, 379);
    line(51, 400, 360, 370, 379);

    ph = 0; cur_x = 0; cur_y = 0; cur_sc = 1;
    vblank_seg();
    ph = 3;
    line(0, 400, 360, 370, 379);
    line(1, 400, 360, 370, 379);
    line(127, 400, 360, 370, 379);
    line(128, 400, 360, 370, 379);

    ph = 0; cur_x = 100; cur_y = 50; cur_sc = 0; cur_en = 0;
    vblank_seg();
    ph = 4;
    line(50, 400, 360, 370, 379);

    ph = 0; cur_en = 1;
    vblank_seg();
    line(50, 800, 640, 656, 751);
    line(51, 800, 640, 656, 751);

    repeat (8) cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    @(negedge pclk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
